// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for an external combinational ALU: registers one command, captures the
// ALU result a cycle later and queues {data, z, c} in a first-word-fall-through result FIFO.
module alu_cmd_sequencer #(
   parameter int N     = 31,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [N:0]             cmd_a,
   input  logic [N:0]             cmd_b,
   input  logic [2:0]             cmd_op,
   output logic [N:0]             alu_a,
   output logic [N:0]             alu_b,
   output logic [2:0]             alu_op,
   input  logic [N:0]             alu_out,
   input  logic                   alu_z,
   input  logic                   alu_c,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [N:0]             res_data,
   output logic                   res_z,
   output logic                   res_c,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = N + 3;

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_e;

   state_e         state_q, state_d;
   logic [N:0]     alu_a_q, alu_a_d;
   logic [N:0]     alu_b_q, alu_b_d;
   logic [2:0]     alu_op_q, alu_op_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [EW-1:0]  mem_q [DEPTH];
   logic [EW-1:0]  head;
   logic           accept;
   logic           wr_en;
   logic           rd_en;

   // Handshakes: a command transfers on a rising edge with cmd_valid && cmd_ready, a result
   // on a rising edge with res_valid && res_ready; the offering side holds its data until then.
   assign cmd_ready = (state_q == IDLE) && (count_q < CW'(DEPTH));
   assign accept    = cmd_valid && cmd_ready;
   assign wr_en     = (state_q == EXEC);
   assign res_valid = (count_q != '0);
   assign rd_en     = res_valid && res_ready;

   always_comb begin
      state_d  = state_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      alu_op_d = alu_op_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               alu_a_d  = cmd_a;
               alu_b_d  = cmd_b;
               alu_op_d = cmd_op;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            state_d  = IDLE;
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         default: state_d = IDLE;
      endcase
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      // A write can never meet a full FIFO because admission already required free space.
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_op_q <= alu_op_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately not reset; the pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= {alu_out, alu_z, alu_c};
      end
   end

   assign head                       = mem_q[rd_ptr_q];
   assign {res_data, res_z, res_c}   = res_valid ? head : '0;
   assign alu_a                      = alu_a_q;
   assign alu_b                      = alu_b_q;
   assign alu_op                     = alu_op_q;
   assign fifo_count                 = count_q;
   assign busy                       = (state_q == EXEC);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a behavioural ALU stand-in, a vector table for single
// commands, and directed sequences for fill, concurrent push/pop and reset during EXEC.
module tb_alu_cmd_sequencer;

   localparam int N     = 31;
   localparam int DEPTH = 4;

   logic                   clk;
   logic                   rst_n;
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [N:0]             cmd_a;
   logic [N:0]             cmd_b;
   logic [2:0]             cmd_op;
   logic [N:0]             alu_a;
   logic [N:0]             alu_b;
   logic [2:0]             alu_op;
   logic [N:0]             alu_out;
   logic                   alu_z;
   logic                   alu_c;
   logic                   res_valid;
   logic                   res_ready;
   logic [N:0]             res_data;
   logic                   res_z;
   logic                   res_c;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   busy;

   int checks = 0;
   int errors = 0;
   logic [N+2:0] exp_q[$];
   logic [N+2:0] sb_exp;

   typedef struct {
      logic [2:0] op;
      logic [N:0] a;
      logic [N:0] b;
      logic [N:0] exp_d;
      logic       exp_z;
      logic       exp_c;
   } vec_t;

   vec_t vecs[10];

   alu_cmd_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_op     (cmd_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_out    (alu_out),
      .alu_z      (alu_z),
      .alu_c      (alu_c),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_z      (res_z),
      .res_c      (res_c),
      .fifo_count (fifo_count),
      .busy       (busy)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ALU: 000 ADD, 001 SUB, 010 MUL, 011 DIV (x/0 = 0), 100 AND, 101 OR, 110 XOR, 111 NOT.
   // c is carry-out for ADD and borrow for SUB, 0 otherwise; z flags a zero result.
   function automatic logic [N+2:0] alu_ref(input logic [N:0] a, input logic [N:0] b,
                                            input logic [2:0] op);
      logic [N+1:0] wide;
      logic [N:0]   r;
      logic         c;
      wide = '0;
      r    = '0;
      c    = 1'b0;
      case (op)
         3'b000: begin wide = {1'b0, a} + {1'b0, b}; r = wide[N:0]; c = wide[N+1]; end
         3'b001: begin wide = {1'b0, a} - {1'b0, b}; r = wide[N:0]; c = wide[N+1]; end
         3'b010: r = a * b;
         3'b011: r = (b == '0) ? '0 : a / b;
         3'b100: r = a & b;
         3'b101: r = a | b;
         3'b110: r = a ^ b;
         default: r = ~a;
      endcase
      return {r, (r == '0), c};
   endfunction

   always_comb {alu_out, alu_z, alu_c} = alu_ref(alu_a, alu_b, alu_op);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: expectations pushed at command transfer, compared at result transfer.
   always @(negedge clk) begin
      if (rst_n) begin
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow: got result 0x%0h with nothing expected", res_data);
            end else begin
               sb_exp = exp_q.pop_front();
               check("sb_result", 64'({res_data, res_z, res_c}), 64'(sb_exp));
            end
         end
         if (cmd_valid && cmd_ready) begin
            exp_q.push_back(alu_ref(cmd_a, cmd_b, cmd_op));
         end
      end
   end

   // Drivers: called away from a clock edge; return just after the accepting edge.
   task automatic issue(input logic [N:0] a, input logic [N:0] b, input logic [2:0] op);
      int t;
      t         = 0;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      cmd_valid = 1'b1;
      @(negedge clk);
      while (!cmd_ready && t < 50) begin
         t++;
         @(negedge clk);
      end
      if (!cmd_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: cmd_ready stayed 0 for op %0d", op);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t         = 0;
      res_ready = 1'b1;
      @(negedge clk);
      while (fifo_count != 0 && t < 40) begin
         t++;
         @(negedge clk);
      end
      check("drain_count", 64'(fifo_count), 64'd0);
      check("drain_valid", 64'(res_valid), 64'd0);
      check("drain_data_zero", 64'({res_data, res_z, res_c}), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{3'b000, 32'd5,          32'd3,          32'd8,          1'b0, 1'b0};
      vecs[1] = '{3'b001, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1'b1};
      vecs[2] = '{3'b011, 32'd7,          32'd0,          32'd0,          1'b1, 1'b0};
      vecs[3] = '{3'b000, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b1};
      vecs[4] = '{3'b100, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  1'b0, 1'b0};
      vecs[5] = '{3'b101, 32'h1200_0000,  32'h0000_0034,  32'h1200_0034,  1'b0, 1'b0};
      vecs[6] = '{3'b110, 32'hAAAA_5555,  32'hAAAA_5555,  32'd0,          1'b1, 1'b0};
      vecs[7] = '{3'b111, 32'd0,          32'd9,          32'hFFFF_FFFF,  1'b0, 1'b0};
      vecs[8] = '{3'b010, 32'd6,          32'd7,          32'd42,         1'b0, 1'b0};
      vecs[9] = '{3'b011, 32'd100,        32'd7,          32'd14,         1'b0, 1'b0};

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_op    = '0;
      res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_count", 64'(fifo_count), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res_zero", 64'({res_data, res_z, res_c}), 64'd0);
      check("rst_alu_a", 64'(alu_a), 64'd0);
      check("rst_alu_b", 64'(alu_b), 64'd0);
      check("rst_alu_op", 64'(alu_op), 64'd0);
      @(posedge clk);
      #1;

      // Single commands: one EXEC cycle, result on the following cycle.
      res_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].op);
         @(negedge clk);
         check("vec_busy", 64'(busy), 64'd1);
         check("vec_not_yet_valid", 64'(res_valid), 64'd0);
         @(negedge clk);
         check("vec_busy_done", 64'(busy), 64'd0);
         check("vec_res_valid", 64'(res_valid), 64'd1);
         check("vec_res_data", 64'(res_data), 64'(vecs[i].exp_d));
         check("vec_res_flags", 64'({res_z, res_c}), 64'({vecs[i].exp_z, vecs[i].exp_c}));
         @(posedge clk);
         #1;
      end
      check("table_queue_empty", 64'(exp_q.size()), 64'd0);

      // Fill the FIFO with the consumer stalled, then free exactly one slot.
      res_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         issue(32'($urandom_range(0, 32'hFFFF_FFFF)), 32'($urandom_range(0, 32'hFFFF_FFFF)),
               3'($urandom_range(0, 7)));
      end
      @(posedge clk);
      #1;
      cmd_a     = 32'($urandom_range(0, 32'hFFFF_FFFF));
      cmd_b     = 32'($urandom_range(0, 255));
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("full_count", 64'(fifo_count), 64'(DEPTH));
         check("full_cmd_ready", 64'(cmd_ready), 64'd0);
         check("full_busy", 64'(busy), 64'd0);
      end
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      @(negedge clk);
      check("after_pop_count", 64'(fifo_count), 64'(DEPTH - 1));
      check("after_pop_cmd_ready", 64'(cmd_ready), 64'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check("fifth_busy", 64'(busy), 64'd1);
      @(negedge clk);
      check("refill_count", 64'(fifo_count), 64'(DEPTH));
      @(posedge clk);
      #1;
      drain();
      check("fill_queue_empty", 64'(exp_q.size()), 64'd0);

      // EXEC write and pop on the same edge with two entries queued.
      res_ready = 1'b0;
      issue(32'd10, 32'd20, 3'b000);
      issue(32'd50, 32'd8, 3'b001);
      issue(32'hFF, 32'h0F, 3'b110);
      res_ready = 1'b1;
      @(negedge clk);
      check("conc_count_before", 64'(fifo_count), 64'd2);
      check("conc_busy", 64'(busy), 64'd1);
      check("conc_head_before", 64'(res_data), 64'd30);
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      @(negedge clk);
      check("conc_count_after", 64'(fifo_count), 64'd2);
      check("conc_head_after", 64'(res_data), 64'd42);
      @(posedge clk);
      #1;
      drain();
      check("conc_queue_empty", 64'(exp_q.size()), 64'd0);

      // Reset while a command is in EXEC with one result already queued.
      res_ready = 1'b0;
      issue(32'd100, 32'd1, 3'b000);
      @(posedge clk);
      #1;
      issue(32'd2, 32'd2, 3'b000);
      check("pre_rst_busy", 64'(busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_count", 64'(fifo_count), 64'd0);
      check("mid_rst_res_valid", 64'(res_valid), 64'd0);
      check("mid_rst_res_zero", 64'({res_data, res_z, res_c}), 64'd0);
      check("mid_rst_alu_a", 64'(alu_a), 64'd0);
      check("mid_rst_alu_op", 64'(alu_op), 64'd0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("post_rst_count", 64'(fifo_count), 64'd0);
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      issue(32'd1, 32'd1, 3'b000);
      @(negedge clk);
      check("post_rst_busy", 64'(busy), 64'd1);
      @(negedge clk);
      check("post_rst_valid", 64'(res_valid), 64'd1);
      check("post_rst_data", 64'(res_data), 64'd2);
      @(posedge clk);
      #1;
      drain();
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have parameter N, default 31, MSB index of every datapath operand and result (width N+1).
REQ-002 SHALL have parameter DEPTH, default 4, result FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have ports cmd_a, cmd_b  input  N+1 each  operands.
REQ-008 SHALL have port cmd_op  input  3  ALU opcode (000 ADD … 111 NOT).
REQ-009 SHALL have ports alu_a, alu_b  output  N+1 each, and alu_op  output  3  registered drive to the downstream combinational ALU.
REQ-010 SHALL have ports alu_out  input  N+1, alu_z  input  1, alu_c  input  1  ALU result and flags.
REQ-011 SHALL have ports res_valid  output  1, res_ready  input  1  result handshake.
REQ-012 SHALL have ports res_data  output  N+1, res_z  output  1, res_c  output  1  head-of-FIFO result.
REQ-013 SHALL have port fifo_count  output  clog2(DEPTH)+1  occupied FIFO entries.
REQ-014 SHALL have port busy  output  1  high while state is EXEC.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, EXEC.
REQ-016 cmd_ready SHALL be combinational: high only in IDLE with fifo_count < DEPTH.
REQ-017 On a clock edge with cmd_valid && cmd_ready, SHALL load cmd_a/cmd_b/cmd_op into alu_a/alu_b/alu_op and enter EXEC.
REQ-018 alu_a/alu_b/alu_op SHALL hold their value until the next accepted command.
REQ-019 In EXEC, on the next clock edge, SHALL write {alu_out, alu_z, alu_c} into the FIFO tail and return to IDLE; no other condition leaves EXEC.
REQ-020 Latency: result visible on res_* exactly one cycle after the EXEC cycle when the FIFO was empty; throughput one command per two cycles.
REQ-021 FIFO SHALL be first-word-fall-through: res_valid = (fifo_count != 0); res_data/res_z/res_c show the head entry.
REQ-022 Pop SHALL occur on a clock edge with res_valid && res_ready; head advances by one.
REQ-023 Simultaneous write (EXEC exit) and pop SHALL leave fifo_count unchanged and preserve order.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; fifo_count SHALL never exceed DEPTH or go below 0.
REQ-025 Admission in IDLE only when not full guarantees the EXEC write never hits a full FIFO; no overflow path exists.
REQ-026 res_ready with res_valid low SHALL have no effect; cmd_valid with cmd_ready low SHALL have no effect and the upstream holds its command.
REQ-027 Flags and data SHALL be stored unmodified from the ALU (no recomputation of z or c).
REQ-028 When res_valid is low, res_data/res_z/res_c SHALL be 0.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, alu_a = 0, alu_b = 0, alu_op = 000, FIFO pointers 0, fifo_count 0, res_valid 0, res_* 0, busy 0.
REQ-030 Reset asserted during EXEC SHALL discard the in-flight result; no FIFO write occurs.
REQ-031 After rst_n deasserts, cmd_ready SHALL be 1 on the first cycle.
REQ-032 FIFO storage contents need not be cleared; only pointers and count are reset.

Verification
REQ-033 ADD: cmd_a=5, cmd_b=3, op=000, res_ready=1 -> busy one cycle; next cycle res_valid=1, res_data=8, res_z=0, res_c=0.
REQ-034 SUB: cmd_a=3, cmd_b=5, op=001 (N=31) -> res_data=0xFFFFFFFE, res_c=1, res_z=0.
REQ-035 Divide by zero: cmd_a=7, cmd_b=0, op=011 -> res_data=0, res_z=1.
REQ-036 Fill: res_ready=0, four back-to-back commands -> fifo_count reaches 4, cmd_ready=0 with cmd_valid held; one pop -> cmd_ready=1, fifth command accepted; results pop in issue order.
REQ-037 Concurrent: fifo_count=2, EXEC exit and pop on the same edge -> fifo_count stays 2; head changes to the second-oldest entry.
REQ-038 Reset mid-EXEC: rst_n low during EXEC -> immediate IDLE, fifo_count=0, res_valid=0; after release a new ADD 1+1 returns res_data=2.
